// File: rtl/mem_bus_master_pkg.sv
// Shared types and default widths for the memory bus master.
package mem_bus_master_pkg;

    localparam int unsigned MBM_AWIDTH = 5;
    localparam int unsigned MBM_DWIDTH = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RSP  = 3'd4
    } mem_bus_state_t;

endpackage

// File: rtl/mem_bus_master.sv
// Request/response front end driving a single-port memory over a shared tristate data bus.
// Strobes, address and read data are all flops so the memory sees glitch-free controls.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int unsigned AWIDTH = MBM_AWIDTH,
    parameter int unsigned DWIDTH = MBM_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    mem_bus_state_t    state_q, state_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              handshake;

    // Gated by rst_n so the requester sees "not ready" while reset is held.
    assign req_ready = rst_n && (state_q == IDLE);
    assign handshake = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        mem_wr_d    = mem_wr_q;
        mem_rd_d    = mem_rd_q;
        rsp_valid_d = rsp_valid_q;
        mem_addr_d  = mem_addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    mem_addr_d = req_addr;
                    wdata_d    = req_wdata;
                    if (req_we) begin
                        state_d  = WR;
                        mem_wr_d = 1'b1;
                    end else begin
                        state_d  = RD1;
                        mem_rd_d = 1'b1;
                    end
                end
            end
            WR: begin
                state_d  = IDLE;
                mem_wr_d = 1'b0;
            end
            RD1: begin
                state_d = RD2;
            end
            RD2: begin
                // Memory has had a full cycle to settle; sample the bus on the closing edge.
                rsp_rdata_d = mem_data;
                mem_rd_d    = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_wr_d    = 1'b0;
                mem_rd_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            rsp_valid_q <= rsp_valid_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    // mem_wr_q is high exactly in WR and cleared by reset, so the bus floats everywhere else.
    assign mem_data = mem_wr_q ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench: behavioural memory on the mem_* bus, vector table plus corner sequences.
module tb_mem_bus_master;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int TMO   = 50;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b1;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_wr;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            hs_cyc;
        logic [AW-1:0] addr;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;
    vec_t vecs[8];

    logic [DW-1:0] mem_array [DEPTH];
    logic [DW-1:0] shadow    [DEPTH];
    logic          mem_loaded     = 1'b0;
    bit            rsp_valid_prev = 1'b0;

    mem_bus_master #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // An undriven bus reads as all ones, which makes a stray master drive visible.
    pullup (mem_data);

    function automatic logic [DW-1:0] pat(int i);
        logic [DW-1:0] v;
        v = DW'(i);
        return v ^ 8'h5A;
    endfunction

    // Memory model: combinational read while mem_rd, write on the clock edge while mem_wr.
    assign mem_data = mem_rd ? mem_array[mem_addr] : {DW{1'bz}};
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) mem_array[i] <= pat(i);
            mem_loaded <= 1'b1;
        end else if (mem_wr) begin
            mem_array[mem_addr] <= mem_data;
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Bus protocol and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("wr_rd_overlap", 32'(mem_wr & mem_rd), 32'd0);
            if (!mem_wr && !mem_rd)
                chk("bus_released", 32'(mem_data), 32'(8'hFF));
            if (rsp_valid && !rsp_valid_prev) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("read_latency", 32'(cyc - sb_q[0].hs_cyc), 32'd3);
                end
            end
            if (rsp_valid && rsp_ready && sb_q.size() != 0) begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(sb_q[0].data));
                $display("RSP  addr=%0d rdata=0x%02h expected=0x%02h", sb_q[0].addr, rsp_rdata, sb_q[0].data);
                void'(sb_q.pop_front());
            end
        end
        rsp_valid_prev = rsp_valid;
    end

    // Call at a negedge; returns at the negedge after the handshake edge.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] exp_rdata, input bit expect_rsp, output int hs_cyc);
        int n;
        n         = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("handshake_timeout", 32'(n), 32'd0);
            req_valid = 1'b0;
            hs_cyc    = -1;
            return;
        end
        hs_cyc = cyc;
        if (!we && expect_rsp) sb_q.push_back('{data: exp_rdata, hs_cyc: cyc, addr: addr});
        if (we) shadow[addr] = wdata;
        @(posedge clk);
        #1;
        if (we) begin
            chk("wr_strobe", 32'(mem_wr), 32'd1);
            chk("wr_no_rd", 32'(mem_rd), 32'd0);
            chk("wr_addr", 32'(mem_addr), 32'(addr));
            chk("wr_bus_data", 32'(mem_data), 32'(wdata));
            $display("WR   addr=%0d wdata=0x%02h", addr, wdata);
        end else begin
            chk("rd_strobe", 32'(mem_rd), 32'd1);
            chk("rd_no_wr", 32'(mem_wr), 32'd0);
            chk("rd_addr", 32'(mem_addr), 32'(addr));
            $display("RD   addr=%0d", addr);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int hs, prev_hs, n;

        for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);
        vecs = '{
            '{we: 1'b1, addr: 5'd5,  wdata: 8'hA5, exp_rdata: 8'h00},
            '{we: 1'b0, addr: 5'd5,  wdata: 8'h00, exp_rdata: 8'hA5},
            '{we: 1'b1, addr: 5'd31, wdata: 8'h3C, exp_rdata: 8'h00},
            '{we: 1'b0, addr: 5'd31, wdata: 8'h00, exp_rdata: 8'h3C},
            '{we: 1'b1, addr: 5'd0,  wdata: 8'h0F, exp_rdata: 8'h00},
            '{we: 1'b0, addr: 5'd0,  wdata: 8'h00, exp_rdata: 8'h0F},
            '{we: 1'b0, addr: 5'd9,  wdata: 8'h00, exp_rdata: 8'h53},
            '{we: 1'b0, addr: 5'd5,  wdata: 8'h00, exp_rdata: 8'hA5}
        };

        // Reset held with a write request pending.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 5'd9;
        req_wdata = 8'h77;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_bus_z", 32'(mem_data), 32'(8'hFF));
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_mem_wr", 32'(mem_wr), 32'd0);
        req_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_no_access", 32'(mem_wr | mem_rd), 32'd0);
        end

        // Table-driven basic traffic.
        for (int v = 0; v < 8; v++)
            issue(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata, 1'b1, hs);
        wait_drain();

        // Full-range write sweep then read-back, checking issue spacing.
        prev_hs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, AW'(i), DW'(i), 8'h00, 1'b0, hs);
            if (i > 0) chk("wr_spacing", 32'(hs - prev_hs), 32'd2);
            prev_hs = hs;
        end
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b0, AW'(i), 8'h00, DW'(i), 1'b1, hs);
            if (i > 0) chk("rd_spacing", 32'(hs - prev_hs), 32'd4);
            prev_hs = hs;
        end
        wait_drain();

        // Response stall: rsp_ready only changes just after a rising edge.
        @(posedge clk);
        #2 rsp_ready = 1'b0;
        @(negedge clk);
        issue(1'b0, 5'd3, 8'h00, 8'h03, 1'b1, hs);
        n = 0;
        while (!rsp_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_rdata", 32'(rsp_rdata), 32'h03);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #2 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stall_release_ready", 32'(req_ready), 32'd1);
        chk("stall_release_valid", 32'(rsp_valid), 32'd0);
        wait_drain();

        // Reset pulse while the read is in RD2: abandoned, no response, memory untouched.
        issue(1'b0, 5'd7, 8'h00, 8'h00, 1'b0, hs);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rd2_rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rd2_rst_bus_z", 32'(mem_data), 32'(8'hFF));
        chk("rd2_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rd2_rst_req_ready", 32'(req_ready), 32'd0);
        chk("rd2_rst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rd2_rst_held_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rd2_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        for (int i = 0; i < DEPTH; i++)
            chk("mem_unchanged", 32'(mem_array[i]), 32'(shadow[i]));
        issue(1'b0, 5'd7, 8'h00, 8'h07, 1'b1, hs);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
